// File: rtl/chan_scan_seq_if.sv
// Channel scan controller bus: scan controls in, channel select and status pulses out.
interface chan_scan_seq_if #(
   parameter int DWELL_W = 8
);
   logic               en;
   logic [7:0]         mask;
   logic [DWELL_W-1:0] dwell;
   logic [2:0]         sel;
   logic               sel_valid;
   logic               step;
   logic               wrap;
   logic               busy;

   // Controller side: takes scan controls, drives the channel index and flags.
   modport slave (
      input  en,
      input  mask,
      input  dwell,
      output sel,
      output sel_valid,
      output step,
      output wrap,
      output busy
   );

   // Host side: drives scan controls, observes the channel index and flags.
   modport master (
      output en,
      output mask,
      output dwell,
      input  sel,
      input  sel_valid,
      input  step,
      input  wrap,
      input  busy
   );
endinterface

// File: rtl/chan_scan_seq.sv
// Circular channel scan controller feeding a 3-to-8 one-hot decoder.
// Walks the enabled channels of an 8-bit mask, holding each for dwell+1 cycles,
// and flags every new visit (step) and every pass through the 7->0 boundary (wrap).
module chan_scan_seq #(
   parameter int DWELL_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   chan_scan_seq_if.slave   bus
);

   typedef enum logic {
      IDLE,
      SCAN
   } state_t;

   state_t             state_q,     state_d;
   logic [2:0]         sel_q,       sel_d;
   logic               sel_valid_q, sel_valid_d;
   logic               step_q,      step_d;
   logic               wrap_q,      wrap_d;
   logic               busy_q,      busy_d;
   logic [DWELL_W-1:0] timer_q,     timer_d;

   logic [2:0]         lowest_sel;
   logic [2:0]         next_sel;

   // First set mask bit found when searching circularly upward from start.
   // Callers only use the result when the mask is non-zero.
   function automatic logic [2:0] first_set(input logic [7:0] m, input logic [2:0] start);
      logic [2:0] idx;
      logic       found;
      first_set = start;
      found     = 1'b0;
      for (int i = 0; i < 8; i++) begin
         idx = start + 3'(i);
         if (!found && m[idx]) begin
            first_set = idx;
            found     = 1'b1;
         end
      end
   endfunction

   // Channel candidates: lowest set bit for a fresh start, next set bit after sel for an advance.
   always_comb begin
      lowest_sel = first_set(bus.mask, 3'd0);
      next_sel   = first_set(bus.mask, sel_q + 3'd1);
   end

   // Next-state logic; en dropping wins over an advance, and the timer reloads at zero.
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      sel_valid_d = sel_valid_q;
      step_d      = 1'b0;
      wrap_d      = 1'b0;
      busy_d      = busy_q;
      timer_d     = timer_q;

      case (state_q)
         IDLE: begin
            sel_valid_d = 1'b0;
            busy_d      = 1'b0;
            if (bus.en && (bus.mask != 8'd0)) begin
               state_d     = SCAN;
               sel_d       = lowest_sel;
               sel_valid_d = 1'b1;
               busy_d      = 1'b1;
               step_d      = 1'b1;
               timer_d     = bus.dwell;
            end
         end

         SCAN: begin
            if (!bus.en) begin
               state_d     = IDLE;
               sel_valid_d = 1'b0;
               busy_d      = 1'b0;
            end else if (timer_q != '0) begin
               timer_d = timer_q - 1'b1;
            end else if (bus.mask == 8'd0) begin
               state_d     = IDLE;
               sel_valid_d = 1'b0;
               busy_d      = 1'b0;
            end else begin
               sel_d   = next_sel;
               timer_d = bus.dwell;
               step_d  = 1'b1;
               wrap_d  = (next_sel <= sel_q);
            end
         end

         default: begin
            state_d     = IDLE;
            sel_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   // State and registered outputs, cleared immediately by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sel_q       <= 3'd0;
         sel_valid_q <= 1'b0;
         step_q      <= 1'b0;
         wrap_q      <= 1'b0;
         busy_q      <= 1'b0;
         timer_q     <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         sel_valid_q <= sel_valid_d;
         step_q      <= step_d;
         wrap_q      <= wrap_d;
         busy_q      <= busy_d;
         timer_q     <= timer_d;
      end
   end

   assign bus.sel       = sel_q;
   assign bus.sel_valid = sel_valid_q;
   assign bus.step      = step_q;
   assign bus.wrap      = wrap_q;
   assign bus.busy      = busy_q;

endmodule

// File: doc/chan_scan_seq.md
Name: chan_scan_seq

Overview:
Sequential scan controller that sits directly upstream of the 3-to-8 one-hot decoder in the channel-select path.
- Steps a 3-bit channel index through the enabled channels of an 8-bit mask in circular order.
- Holds each index for a programmable dwell time.
- The decoder turns sel into the 8 one-hot channel enables (display digit / LED / mux strobes).
- Also flags each step and each wrap-around for downstream bookkeeping.

Parameters:
DWELL_W, 8, width of dwell count input and internal dwell timer

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  scan enable; level-sensitive
mask  input  8  channel enable mask; bit i=1 means channel i is visited
dwell  input  DWELL_W  hold count; each channel held dwell+1 cycles
sel  output  3  current channel index, feeds decoder input
sel_valid  output  1  sel is meaningful; gate for decoder output
step  output  1  one-cycle pulse: sel changed to a new visit this cycle
wrap  output  1  one-cycle pulse: this step passed through channel 7→0 boundary or revisited same channel
busy  output  1  high in SCAN state

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; sel=3'd0, sel_valid=0, step=0, wrap=0, busy=0; timer=0. Applies immediately mid-scan; scan restarts from IDLE after release.
- States: IDLE, SCAN. All outputs registered.
- IDLE:
  - sel_valid=0, busy=0; sel holds its last value.
  - If en=1 and mask!=0 at edge N, then at N+1: state=SCAN, sel=lowest set bit index of mask, sel_valid=1, busy=1, step=1, wrap=0, timer=dwell.
  - If en=1 and mask==0: remain IDLE.
- SCAN, timer!=0: timer decrements by 1; sel unchanged; step=0, wrap=0.
- SCAN, timer==0 (advance edge):
  - Compute next = first index j with mask[j]=1, searching circularly from sel+1 (mod 8) through sel inclusive.
  - sel=next, timer reloaded from current dwell, step=1.
  - wrap=1 iff next<=old sel; this includes the single-enabled-channel case, where next==sel.
- Timing and sampling:
  - Each visit lasts exactly dwell+1 cycles. With dwell=0, sel advances every cycle and step stays high continuously.
  - mask and dwell are sampled only at entry and at advance edges. Mask changes mid-dwell never cut the current visit short, even if the current channel is de-masked.
  - If mask==0 at an advance edge: go to IDLE; sel_valid=0, busy=0, step=0, wrap=0; sel holds.
- en deasserted in SCAN at any edge: next cycle IDLE, sel_valid=0, busy=0, step=0, wrap=0; sel holds. This takes priority over advance.
- Re-enable from IDLE always restarts from the lowest set mask bit, not the held sel.
- step and wrap are never high while sel_valid=0.
- Index arithmetic is 3-bit modulo 8; timer is DWELL_W bits and never underflows (reload takes priority at 0).

Test Plan:
- Full scan: mask=8'hFF, dwell=2, en=1 after reset → sel=0 one cycle after en, then 1,2,…,7,0, each held 3 cycles. step pulses on every change; wrap=1 only on the 7→0 step.
- Sparse mask: mask=8'b1010_0100, dwell=0 → sel sequence 2,5,7,2,5,7… changing every cycle, step constantly 1, wrap=1 on each 7→2 step.
- Single channel: mask=8'h08, dwell=3 → sel stays 3, sel_valid=1; step=1 and wrap=1 together every 4 cycles.
- Mid-dwell mask change: mask=8'hFF, dwell=5; clear mask bit of current sel 2 cycles into the visit → visit still lasts 6 cycles, next sel skips the cleared channel. Setting mask=0 instead → IDLE at the advance edge, sel_valid=0, sel held.
- en drop and restart: drop en during SCAN at sel=4 → next cycle sel_valid=0, busy=0, sel=4. Raise en with mask=8'h30 → sel=4 then 5, starting from the lowest set bit.
- Async reset mid-scan: assert rst_n=0 between clock edges while sel=6 → sel=0, sel_valid=0, step=0, wrap=0, busy=0 immediately without a clock edge. After release with en=1, mask=8'hFF → sel=0 one cycle later.
